// File: rtl/multicycle_control_fsm.sv
// Main control sequencer for the multicycle MIPS-subset datapath (Moore FSM, registered controls).
// Optional feature: define MEM_WAIT_EN to stall FETCH/MEMRD/MEMWR on MemReady with a timeout.
module multicycle_control_fsm #(
    parameter int OPW          = 6,
    parameter int WAIT_TIMEOUT = 15
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [OPW-1:0] Opcode,
    input  logic           Zero,
    input  logic           MemReady,
    output logic           PCWrite,
    output logic           PCWriteCond,
    output logic           IorD,
    output logic           MemRead,
    output logic           MemWrite,
    output logic           IRWrite,
    output logic           MemtoReg,
    output logic           RegDst,
    output logic           RegWrite,
    output logic           ALUSrcA,
    output logic [1:0]     ALUSrcB,
    output logic [1:0]     ALUOp,
    output logic [1:0]     PCSource,
    output logic [1:0]     SignExtSelect,
    output logic           IllegalOp,
    output logic           MemErr,
    output logic [3:0]     State
);

    typedef enum logic [3:0] {
        RESET  = 4'd0,
        FETCH  = 4'd1,
        DECODE = 4'd2,
        MEMADR = 4'd3,
        MEMRD  = 4'd4,
        MEMWB  = 4'd5,
        MEMWR  = 4'd6,
        REXEC  = 4'd7,
        RWB    = 4'd8,
        BRANCH = 4'd9,
        JUMP   = 4'd10,
        IEXEC  = 4'd11,
        IWB    = 4'd12
    } state_t;

    typedef struct packed {
        logic       pcWrite;
        logic       pcWriteCond;
        logic       iorD;
        logic       memRead;
        logic       memWrite;
        logic       irWrite;
        logic       memtoReg;
        logic       regDst;
        logic       regWrite;
        logic       aluSrcA;
        logic [1:0] aluSrcB;
        logic [1:0] aluOp;
        logic [1:0] pcSource;
        logic [1:0] signExtSelect;
    } ctrlWord_t;

    localparam logic [OPW-1:0] OP_RTYPE = OPW'('h00);
    localparam logic [OPW-1:0] OP_J     = OPW'('h02);
    localparam logic [OPW-1:0] OP_BEQ   = OPW'('h04);
    localparam logic [OPW-1:0] OP_ADDI  = OPW'('h08);
    localparam logic [OPW-1:0] OP_ANDI  = OPW'('h0C);
    localparam logic [OPW-1:0] OP_ORI   = OPW'('h0D);
    localparam logic [OPW-1:0] OP_LUI   = OPW'('h0F);
    localparam logic [OPW-1:0] OP_LW    = OPW'('h23);
    localparam logic [OPW-1:0] OP_SW    = OPW'('h2B);

    // Extender mode for the immediate group: zero-extend logical ops, upper-load for lui.
    function automatic logic [1:0] immExtMode(input logic [OPW-1:0] op);
        logic [1:0] mode;
        mode = 2'b00;
        if (op == OP_ADDI) mode = 2'b01;
        else if (op == OP_LUI) mode = 2'b10;
        return mode;
    endfunction

    function automatic logic isLegal(input logic [OPW-1:0] op);
        return (op == OP_LW) || (op == OP_SW) || (op == OP_RTYPE) || (op == OP_BEQ) ||
               (op == OP_J) || (op == OP_ADDI) || (op == OP_ANDI) || (op == OP_ORI) ||
               (op == OP_LUI);
    endfunction

    function automatic ctrlWord_t decodeState(input state_t s, input logic [OPW-1:0] op);
        ctrlWord_t c;
        c = '0;
        case (s)
            FETCH: begin
                c.memRead = 1'b1;
                c.irWrite = 1'b1;
                c.pcWrite = 1'b1;
                c.aluSrcB = 2'b01;
            end
            DECODE: begin
                c.aluSrcB       = 2'b11;
                c.signExtSelect = 2'b01;
            end
            MEMADR: begin
                c.aluSrcA       = 1'b1;
                c.aluSrcB       = 2'b10;
                c.signExtSelect = 2'b01;
            end
            MEMRD: begin
                c.memRead = 1'b1;
                c.iorD    = 1'b1;
            end
            MEMWB: begin
                c.regWrite = 1'b1;
                c.memtoReg = 1'b1;
            end
            MEMWR: begin
                c.memWrite = 1'b1;
                c.iorD     = 1'b1;
            end
            REXEC: begin
                c.aluSrcA = 1'b1;
                c.aluOp   = 2'b10;
            end
            RWB: begin
                c.regWrite = 1'b1;
                c.regDst   = 1'b1;
            end
            BRANCH: begin
                c.aluSrcA     = 1'b1;
                c.aluOp       = 2'b01;
                c.pcWriteCond = 1'b1;
                c.pcSource    = 2'b01;
            end
            JUMP: begin
                c.pcWrite  = 1'b1;
                c.pcSource = 2'b10;
            end
            IEXEC: begin
                c.aluSrcA       = 1'b1;
                c.aluSrcB       = 2'b10;
                c.aluOp         = 2'b11;
                c.signExtSelect = immExtMode(op);
            end
            IWB: begin
                c.regWrite      = 1'b1;
                c.signExtSelect = immExtMode(op);
            end
            default: c = '0;
        endcase
        return c;
    endfunction

    state_t    state;
    state_t    nextState;
    ctrlWord_t ctrlQ;
    logic      memErrQ;
    logic      memDone;
    logic      waitExpired;

    // The PC compare result is consumed by the datapath's PCWriteCond gating, not by the sequencer.
    logic unusedZero;
    assign unusedZero = Zero;

`ifdef MEM_WAIT_EN
    localparam int WAIT_W = (WAIT_TIMEOUT > 1) ? $clog2(WAIT_TIMEOUT) : 1;

    logic [WAIT_W-1:0] waitCnt;
    logic              inWait;

    assign inWait      = (state == FETCH) || (state == MEMRD) || (state == MEMWR);
    assign memDone     = MemReady;
    assign waitExpired = inWait && !MemReady && (waitCnt == WAIT_W'(WAIT_TIMEOUT - 1));
`else
    localparam int unusedWaitTimeout = WAIT_TIMEOUT;

    logic unusedMemReady;
    assign unusedMemReady = MemReady;
    assign memDone        = 1'b1;
    assign waitExpired    = 1'b0;
`endif

    // NOTE: every variable assigned in always_comb gets a default first so no latch is inferred.
    always_comb begin
        nextState = FETCH;
        case (state)
            RESET:  nextState = FETCH;
            FETCH:  nextState = memDone ? DECODE : FETCH;
            DECODE: begin
                if ((Opcode == OP_LW) || (Opcode == OP_SW))           nextState = MEMADR;
                else if (Opcode == OP_RTYPE)                            nextState = REXEC;
                else if (Opcode == OP_BEQ)                              nextState = BRANCH;
                else if (Opcode == OP_J)                                nextState = JUMP;
                else if ((Opcode == OP_ADDI) || (Opcode == OP_ANDI) ||
                         (Opcode == OP_ORI)  || (Opcode == OP_LUI))     nextState = IEXEC;
                else                                                    nextState = FETCH;
            end
            MEMADR: nextState = (Opcode == OP_SW) ? MEMWR : MEMRD;
            MEMRD:  nextState = memDone ? MEMWB : (waitExpired ? FETCH : MEMRD);
            MEMWB:  nextState = FETCH;
            MEMWR:  nextState = (memDone || waitExpired) ? FETCH : MEMWR;
            REXEC:  nextState = RWB;
            RWB:    nextState = FETCH;
            BRANCH: nextState = FETCH;
            JUMP:   nextState = FETCH;
            IEXEC:  nextState = IWB;
            IWB:    nextState = FETCH;
            default: nextState = FETCH;
        endcase
    end

    // Controls are registered from the next state, so they change in lockstep with the state register.
    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= RESET;
            ctrlQ   <= '0;
            memErrQ <= 1'b0;
`ifdef MEM_WAIT_EN
            waitCnt <= '0;
`endif
        end else begin
            state   <= nextState;
            ctrlQ   <= decodeState(nextState, Opcode);
            memErrQ <= waitExpired;
`ifdef MEM_WAIT_EN
            // Any exit, retry or ready cycle restarts the count for the next access.
            if (inWait && !MemReady && !waitExpired) waitCnt <= waitCnt + 1'b1;
            else                                     waitCnt <= '0;
`endif
        end
    end

    // PC/IR update only once the fetch actually completes (always true with single-cycle memory).
    assign PCWrite       = ctrlQ.pcWrite & ((state != FETCH) | memDone);
    assign IRWrite       = ctrlQ.irWrite & memDone;
    assign PCWriteCond   = ctrlQ.pcWriteCond;
    assign IorD          = ctrlQ.iorD;
    assign MemRead       = ctrlQ.memRead;
    assign MemWrite      = ctrlQ.memWrite;
    assign MemtoReg      = ctrlQ.memtoReg;
    assign RegDst        = ctrlQ.regDst;
    assign RegWrite      = ctrlQ.regWrite;
    assign ALUSrcA       = ctrlQ.aluSrcA;
    assign ALUSrcB       = ctrlQ.aluSrcB;
    assign ALUOp         = ctrlQ.aluOp;
    assign PCSource      = ctrlQ.pcSource;
    assign SignExtSelect = ctrlQ.signExtSelect;
    assign IllegalOp     = (state == DECODE) && !isLegal(Opcode);
    assign MemErr        = memErrQ;
    assign State         = state;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Directed bench for multicycle_control_fsm: walks each instruction class through its state sequence.
// The MEM_WAIT_EN section runs only when the design is built with that macro.
module tb_multicycle_control_fsm;

    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] Opcode;
    logic       Zero;
    logic       MemReady;
    logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
    logic       MemtoReg, RegDst, RegWrite, ALUSrcA, IllegalOp, MemErr;
    logic [1:0] ALUSrcB, ALUOp, PCSource, SignExtSelect;
    logic [3:0] State;

    int total  = 0;
    int passed = 0;
    int failed = 0;

    multicycle_control_fsm #(.OPW(6), .WAIT_TIMEOUT(15)) dut (
        .clk(clk), .rst(rst), .Opcode(Opcode), .Zero(Zero), .MemReady(MemReady),
        .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD), .MemRead(MemRead),
        .MemWrite(MemWrite), .IRWrite(IRWrite), .MemtoReg(MemtoReg), .RegDst(RegDst),
        .RegWrite(RegWrite), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
        .PCSource(PCSource), .SignExtSelect(SignExtSelect), .IllegalOp(IllegalOp),
        .MemErr(MemErr), .State(State)
    );

    always #5 clk = ~clk;

    // Output vector order: PCWrite PCWriteCond IorD MemRead MemWrite IRWrite MemtoReg RegDst RegWrite
    // ALUSrcA ALUSrcB[1:0] ALUOp[1:0] PCSource[1:0] SignExtSelect[1:0] IllegalOp MemErr
    logic [19:0] outs;
    assign outs = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegDst,
                   RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource, SignExtSelect, IllegalOp, MemErr};

    localparam logic [19:0] E_ZERO   = 20'h00000;
    localparam logic [19:0] E_FETCH  = {10'b1001010000, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00};
    localparam logic [19:0] E_DECODE = {10'b0000000000, 2'b11, 2'b00, 2'b00, 2'b01, 2'b00};
    localparam logic [19:0] E_MEMADR = {10'b0000000001, 2'b10, 2'b00, 2'b00, 2'b01, 2'b00};
    localparam logic [19:0] E_MEMRD  = {10'b0011000000, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00};
    localparam logic [19:0] E_MEMWB  = {10'b0000001010, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00};
    localparam logic [19:0] E_MEMWR  = {10'b0010100000, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00};
    localparam logic [19:0] E_REXEC  = {10'b0000000001, 2'b00, 2'b10, 2'b00, 2'b00, 2'b00};
    localparam logic [19:0] E_RWB    = {10'b0000000110, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00};
    localparam logic [19:0] E_BRANCH = {10'b0100000001, 2'b00, 2'b01, 2'b01, 2'b00, 2'b00};
    localparam logic [19:0] E_JUMP   = {10'b1000000000, 2'b00, 2'b00, 2'b10, 2'b00, 2'b00};
    localparam logic [19:0] E_IEXEC  = {10'b0000000001, 2'b10, 2'b11, 2'b00, 2'b00, 2'b00};
    localparam logic [19:0] E_IWB    = {10'b0000000010, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00};

    function automatic logic [19:0] withExt(input logic [19:0] e, input logic [1:0] sx);
        return e | {16'h0000, sx, 2'b00};
    endfunction

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        assert (observed === expected) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic checkNow(input string tag, input logic [3:0] expState, input logic [19:0] expOuts);
        check($sformatf("%s state", tag), 32'(State), 32'(expState));
        check($sformatf("%s ctrl", tag), 32'(outs), 32'(expOuts));
    endtask

    task automatic step(input string tag, input logic [3:0] expState, input logic [19:0] expOuts);
        @(posedge clk);
        #1;
        checkNow(tag, expState, expOuts);
    endtask

    task automatic runImm(input string tag, input logic [5:0] op, input logic [1:0] sx);
        Opcode = op;
        step({tag, " decode"}, 4'd2,  E_DECODE);
        step({tag, " iexec"},  4'd11, withExt(E_IEXEC, sx));
        step({tag, " iwb"},    4'd12, withExt(E_IWB, sx));
        step({tag, " fetch"},  4'd1,  E_FETCH);
    endtask

    initial begin
        rst      = 1'b1;
        Opcode   = 6'h00;
        Zero     = 1'b0;
        MemReady = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checkNow("reset held", 4'd0, E_ZERO);
        rst = 1'b0;
        #1;
        checkNow("reset released", 4'd0, E_ZERO);
        step("first fetch", 4'd1, E_FETCH);

        // Abort a load in MEMRD with an asynchronous reset.
        Opcode = 6'h23;
        step("abort decode", 4'd2, E_DECODE);
        step("abort memadr", 4'd3, E_MEMADR);
        step("abort memrd",  4'd4, E_MEMRD);
        rst = 1'b1;
        #1;
        checkNow("abort async reset", 4'd0, E_ZERO);
        @(posedge clk);
        #1;
        rst = 1'b0;
        checkNow("abort after release", 4'd0, E_ZERO);
        step("abort refetch", 4'd1, E_FETCH);

        // lw: 5 cycles
        step("lw decode", 4'd2, E_DECODE);
        step("lw memadr", 4'd3, E_MEMADR);
        step("lw memrd",  4'd4, E_MEMRD);
        step("lw memwb",  4'd5, E_MEMWB);
        step("lw fetch",  4'd1, E_FETCH);

        runImm("lui",  6'h0F, 2'b10);
        runImm("ori",  6'h0D, 2'b00);
        runImm("addi", 6'h08, 2'b01);
        runImm("andi", 6'h0C, 2'b00);

        Opcode = 6'h00;
        step("r decode", 4'd2, E_DECODE);
        step("r rexec",  4'd7, E_REXEC);
        step("r rwb",    4'd8, E_RWB);
        step("r fetch",  4'd1, E_FETCH);

        Opcode = 6'h2B;
        step("sw decode", 4'd2, E_DECODE);
        step("sw memadr", 4'd3, E_MEMADR);
        step("sw memwr",  4'd6, E_MEMWR);
        step("sw fetch",  4'd1, E_FETCH);

        Opcode = 6'h04;
        Zero   = 1'b0;
        step("beq z0 decode", 4'd2, E_DECODE);
        step("beq z0 branch", 4'd9, E_BRANCH);
        step("beq z0 fetch",  4'd1, E_FETCH);
        Zero = 1'b1;
        step("beq z1 decode", 4'd2, E_DECODE);
        step("beq z1 branch", 4'd9, E_BRANCH);
        step("beq z1 fetch",  4'd1, E_FETCH);
        Zero = 1'b0;

        Opcode = 6'h02;
        step("j decode", 4'd2,  E_DECODE);
        step("j jump",   4'd10, E_JUMP);
        step("j fetch",  4'd1,  E_FETCH);

        Opcode = 6'h3F;
        step("illegal decode", 4'd2, E_DECODE | 20'h00002);
        step("illegal fetch",  4'd1, E_FETCH);

`ifdef MEM_WAIT_EN
        // Store stalled three cycles in MEMWR, then completes.
        Opcode = 6'h2B;
        step("wsw decode", 4'd2, E_DECODE);
        step("wsw memadr", 4'd3, E_MEMADR);
        MemReady = 1'b0;
        step("wsw memwr c1", 4'd6, E_MEMWR);
        step("wsw memwr c2", 4'd6, E_MEMWR);
        step("wsw memwr c3", 4'd6, E_MEMWR);
        step("wsw memwr c4", 4'd6, E_MEMWR);
        MemReady = 1'b1;
        step("wsw fetch", 4'd1, E_FETCH);

        // Store that never sees MemReady: timeout after 15 cycles in MEMWR.
        step("tsw decode", 4'd2, E_DECODE);
        step("tsw memadr", 4'd3, E_MEMADR);
        MemReady = 1'b0;
        step("tsw memwr enter", 4'd6, E_MEMWR);
        for (int i = 0; i < 14; i++) @(posedge clk);
        #1;
        checkNow("tsw memwr last", 4'd6, E_MEMWR);
        // FETCH with memory not ready: PCWrite/IRWrite suppressed, MemErr pulsing.
        step("tsw err fetch", 4'd1, (E_FETCH & ~20'h84000) | 20'h00001);
        MemReady = 1'b1;
        #1;
        checkNow("tsw fetch ready", 4'd1, E_FETCH | 20'h00001);
        step("tsw retry decode", 4'd2, E_DECODE);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
